datapath_core: RTL and testbench

- 64-bit single-cycle LEGv8-style datapath: 32x64 register file, 64-bit ALU, 4096x64 unified instruction/data RAM, PC, instruction register (IR) and status-flag register.
- Driven entirely by an external control unit through control-word inputs.
- Exports the fetched instruction and the status flags back to that control unit.

---
 rtl/datapath_core_pkg.sv | 35 +++
 rtl/datapath_core_alu.sv | 46 ++++
 rtl/datapath_core.sv | 125 ++++++++++++
 tb/tb_datapath_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_core_pkg.sv
// Shared encodings for the LEGv8-style datapath: ALU opcodes, D-bus and PC
// update selects, status-flag bit positions and the default reset PC.
package datapath_core_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h800;

  // ALU operation, carried in FS[4:2]
  localparam logic [2:0] FS_AND   = 3'b000;
  localparam logic [2:0] FS_OR    = 3'b001;
  localparam logic [2:0] FS_ADD   = 3'b010;
  localparam logic [2:0] FS_XOR   = 3'b011;
  localparam logic [2:0] FS_LSL   = 3'b100;
  localparam logic [2:0] FS_LSR   = 3'b101;
  localparam logic [2:0] FS_PASSA = 3'b110;
  localparam logic [2:0] FS_PASSB = 3'b111;

  // Register write-data source, carried in DS[1:0]
  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_PC1 = 2'b01;
  localparam logic [1:0] DS_K   = 2'b10;
  localparam logic [1:0] DS_MEM = 2'b11;

  // PC update select
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_ABS  = 2'b11;

  // Status word is {V,C,N,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/datapath_core_alu.sv
// Combinational 64-bit ALU: optional operand inversion, eight operations,
// and {V,C,N,Z} flags where C and V are meaningful only for the adder.
module dp_alu
  import datapath_core_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [4:0]  fs,
  input  logic        c0,
  output logic [63:0] f,
  output logic [3:0]  flags
);

  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [64:0] sum;

  assign a_in = fs[1] ? ~a : a;
  assign b_in = fs[0] ? ~b : b;
  assign sum  = {1'b0, a_in} + {1'b0, b_in} + {64'd0, c0};

  // Operation select and flag generation
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    f     = '0;
    flags = '0;
    case (fs[4:2])
      FS_AND:   f = a_in & b_in;
      FS_OR:    f = a_in | b_in;
      FS_ADD:   f = sum[63:0];
      FS_XOR:   f = a_in ^ b_in;
      FS_LSL:   f = a_in << b_in[5:0];
      FS_LSR:   f = a_in >> b_in[5:0];
      FS_PASSA: f = a_in;
      FS_PASSB: f = b_in;
      default:  f = '0;
    endcase
    flags[FLAG_Z] = (f == 64'd0);
    flags[FLAG_N] = f[63];
    if (fs[4:2] == FS_ADD) begin
      flags[FLAG_C] = sum[64];
      flags[FLAG_V] = (a_in[63] == b_in[63]) && (sum[63] != a_in[63]);
    end
  end

endmodule

// File: rtl/datapath_core.sv
// Single-cycle LEGv8-style datapath: register file, ALU, unified RAM, PC,
// IR and status register, all sequenced by an external control word.
module datapath_core
  import datapath_core_pkg::*;
#(
  parameter int          ADDR_BITS = 12,
  parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AS,
  input  logic [2:0]  DS,
  input  logic [1:0]  PS,
  input  logic        PC_Sel,
  input  logic        K_Sel,
  input  logic        IL,
  input  logic        SL,
  input  logic [4:0]  FS,
  input  logic        C0,
  input  logic        MW,
  input  logic        RW,
  input  logic [4:0]  DA,
  input  logic [4:0]  SA,
  input  logic [4:0]  SB,
  input  logic [63:0] K,
  output logic [3:0]  SF,
  output logic [31:0] IR_Out
);

  logic [63:0]          pc;
  logic [31:0]          ir;
  logic [3:0]           sf;
  logic [63:0]          regs [0:31];
  logic [63:0]          mem  [0:(2**ADDR_BITS)-1];

  logic [63:0]          a_bus;
  logic [63:0]          b_bus;
  logic [63:0]          alu_a;
  logic [63:0]          alu_b;
  logic [63:0]          alu_f;
  logic [3:0]           alu_flags;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [63:0]          mem_rdata;
  logic [63:0]          pc_inc;
  logic [63:0]          d_bus;
  logic [63:0]          pc_next;
  logic                 unused_ds;

  // X31 is the zero register: reads are forced to 0 regardless of contents
  assign a_bus     = (SA == 5'd31) ? 64'd0 : regs[SA];
  assign b_bus     = (SB == 5'd31) ? 64'd0 : regs[SB];
  assign alu_a     = AS ? pc : a_bus;
  assign alu_b     = K_Sel ? K : b_bus;
  assign mem_addr  = IL ? pc[ADDR_BITS-1:0] : alu_f[ADDR_BITS-1:0];
  assign mem_rdata = mem[mem_addr];
  assign pc_inc    = pc + 64'd1;
  assign unused_ds = DS[2];
  assign SF        = sf;
  assign IR_Out    = ir;

  dp_alu u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .fs    (FS),
    .c0    (C0),
    .f     (alu_f),
    .flags (alu_flags)
  );

  // Register write-data source select
  always_comb begin
    d_bus = alu_f;
    case (DS[1:0])
      DS_ALU:  d_bus = alu_f;
      DS_PC1:  d_bus = pc_inc;
      DS_K:    d_bus = K;
      DS_MEM:  d_bus = mem_rdata;
      default: d_bus = alu_f;
    endcase
  end

  // Next-PC select; relative and absolute targets wrap at 64 bits
  always_comb begin
    pc_next = pc;
    case (PS)
      PS_HOLD: pc_next = pc;
      PS_INC:  pc_next = pc_inc;
      PS_REL:  pc_next = pc + K;
      PS_ABS:  pc_next = PC_Sel ? K : a_bus;
      default: pc_next = pc;
    endcase
  end

  // Register file write; writes to X31 are dropped
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every write this edge sees pre-edge values.
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RW && (DA != 5'd31)) begin
      regs[DA] <= d_bus;
    end
  end

  // RAM write from the B register bus; reset suppresses the write
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset so it maps onto plain memory; software must not assume its contents.
    if (MW && !rst) begin
      mem[mem_addr] <= b_bus;
    end
  end

  // PC, instruction register and status register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      sf <= '0;
    end else begin
      pc <= pc_next;
      if (IL) ir <= mem_rdata[31:0];
      if (SL) sf <= alu_flags;
    end
  end

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: each control word pushes its expected
// results into a scoreboard; a negedge monitor pops and compares them.
module tb_datapath_core;
  import datapath_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        AS;
  logic [2:0]  DS;
  logic [1:0]  PS;
  logic        PC_Sel;
  logic        K_Sel;
  logic        IL;
  logic        SL;
  logic [4:0]  FS;
  logic        C0;
  logic        MW;
  logic        RW;
  logic [4:0]  DA;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [63:0] K;
  logic [3:0]  SF;
  logic [31:0] IR_Out;

  always #5 clk = ~clk;

  datapath_core dut (
    .clk(clk), .rst(rst), .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel),
    .K_Sel(K_Sel), .IL(IL), .SL(SL), .FS(FS), .C0(C0), .MW(MW), .RW(RW),
    .DA(DA), .SA(SA), .SB(SB), .K(K), .SF(SF), .IR_Out(IR_Out)
  );

  typedef enum int {OB_IR, OB_SF, OB_PC, OB_REG, OB_MEM, OB_ABUS} obs_t;
  typedef struct {
    int          cyc;
    obs_t        kind;
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [63:0] act;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  localparam logic [4:0] F_ADD   = 5'b01000;
  localparam logic [4:0] F_SUB   = 5'b01001;
  localparam logic [4:0] F_AND   = 5'b00000;
  localparam logic [4:0] F_OR    = 5'b00100;
  localparam logic [4:0] F_XOR   = 5'b01100;
  localparam logic [4:0] F_LSL   = 5'b10000;
  localparam logic [4:0] F_LSR   = 5'b10100;
  localparam logic [4:0] F_PASSA = 5'b11000;
  localparam logic [4:0] F_PASSB = 5'b11100;
  localparam logic [4:0] F_NOTB  = 5'b11101;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] observe(obs_t k, int idx);
    case (k)
      OB_IR:   return {32'd0, IR_Out};
      OB_SF:   return {60'd0, SF};
      OB_PC:   return dut.pc;
      OB_REG:  return dut.regs[idx];
      OB_MEM:  return dut.mem[idx];
      OB_ABUS: return dut.a_bus;
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: compare every expectation due by this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      act = observe(cur.kind, cur.idx);
      checks++;
      if (act !== cur.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.val);
      end
    end
  end

  task automatic clr();
    rst = 0; AS = 0; DS = 0; PS = 0; PC_Sel = 0; K_Sel = 0; IL = 0; SL = 0;
    FS = 0; C0 = 0; MW = 0; RW = 0; DA = 0; SA = 0; SB = 0; K = 0;
  endtask

  task automatic expect_v(obs_t k, int idx, logic [63:0] v, string name);
    exp_t e;
    e.cyc = cyc + 1; e.kind = k; e.idx = idx; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    @(negedge clk); #1;
    rst = 1; tick();

    // Preload RAM[0x800] through the datapath: X5 <= K, then STUR X5
    clr(); DS = 3'b010; K = 64'h91001FE2; RW = 1; DA = 5;
    expect_v(OB_REG, 5, 64'h91001FE2, "preload_x5"); tick();
    clr(); SA = 31; SB = 5; K_Sel = 1; K = 64'h800; FS = F_ADD; MW = 1;
    expect_v(OB_MEM, 'h800, 64'h91001FE2, "preload_mem800"); tick();

    // Dirty IR and SF so the reset below has something to clear
    clr(); IL = 1; PS = PS_INC; SL = 1; K_Sel = 1; K = 0; FS = F_PASSB;
    expect_v(OB_IR, 0, 64'h91001FE2, "dirty_ir");
    expect_v(OB_SF, 0, 64'h1, "dirty_sf_z");
    expect_v(OB_PC, 0, 64'h801, "dirty_pc"); tick();

    // Reset wins over simultaneous writes
    clr(); rst = 1; RW = 1; DA = 5; DS = 3'b010; K = 1; PS = PS_INC; IL = 1; SL = 1;
    expect_v(OB_PC, 0, 64'h800, "reset_pc");
    expect_v(OB_IR, 0, 64'h0, "reset_ir");
    expect_v(OB_SF, 0, 64'h0, "reset_sf");
    expect_v(OB_REG, 5, 64'h0, "reset_x5"); tick();

    // Fetch
    clr(); IL = 1; PS = PS_INC;
    expect_v(OB_IR, 0, 64'h91001FE2, "fetch_ir");
    expect_v(OB_PC, 0, 64'h801, "fetch_pc"); tick();

    // ADDI X2 = X31 + 7
    clr(); SA = 31; K = 7; K_Sel = 1; FS = F_ADD; DS = 3'b000; DA = 2; RW = 1;
    expect_v(OB_REG, 2, 64'd7, "addi_x2");
    expect_v(OB_PC, 0, 64'h801, "exec_pc_hold"); tick();
    clr(); IL = 1; PS = PS_INC;
    expect_v(OB_PC, 0, 64'h802, "fetch2_pc"); tick();
    clr(); SA = 2; K = 14; K_Sel = 1; FS = F_ADD; DA = 3; RW = 1;
    expect_v(OB_REG, 3, 64'd21, "addi_x3");
    expect_v(OB_PC, 0, 64'h802, "addi_pc"); tick();

    // STUR X3 -> RAM[X2+14]
    clr(); SA = 2; SB = 3; K = 14; K_Sel = 1; FS = F_ADD; MW = 1;
    expect_v(OB_MEM, 21, 64'd21, "stur_mem21");
    expect_v(OB_REG, 2, 64'd7, "stur_x2_kept");
    expect_v(OB_REG, 3, 64'd21, "stur_x3_kept"); tick();

    // LDUR X1 <- RAM[X3+0]
    clr(); SA = 3; K = 0; K_Sel = 1; FS = F_ADD; DS = 3'b011; DA = 1; RW = 1;
    expect_v(OB_REG, 1, 64'd21, "ldur_x1"); tick();

    // SUBS X31 = X4 - X4 with X4 = 5
    clr(); DS = 3'b010; K = 5; DA = 4; RW = 1;
    expect_v(OB_REG, 4, 64'd5, "load_x4"); tick();
    clr(); SA = 4; SB = 4; FS = F_SUB; C0 = 1; SL = 1; RW = 1; DA = 31;
    expect_v(OB_SF, 0, 64'b0101, "subs_sf"); tick();
    clr(); SA = 31;
    expect_v(OB_ABUS, 0, 64'd0, "x31_reads_zero");
    expect_v(OB_SF, 0, 64'b0101, "sf_hold_sl0"); tick();

    // ALU operation coverage
    clr(); DS = 3'b010; K = 64'h7FFF_FFFF_FFFF_FFFF; DA = 6; RW = 1; tick();
    clr(); SA = 4; K_Sel = 1; K = 4; FS = F_LSL; DA = 7; RW = 1;
    expect_v(OB_REG, 7, 64'h50, "lsl"); tick();
    clr(); SA = 6; K_Sel = 1; K = 62; FS = F_LSR; DA = 8; RW = 1;
    expect_v(OB_REG, 8, 64'h1, "lsr"); tick();
    clr(); SA = 4; K_Sel = 1; K = 3; FS = F_XOR; DA = 9; RW = 1;
    expect_v(OB_REG, 9, 64'h6, "xor"); tick();
    clr(); SA = 4; K_Sel = 1; K = 64'h30; FS = F_OR; DA = 9; RW = 1;
    expect_v(OB_REG, 9, 64'h35, "or"); tick();
    clr(); SA = 6; K_Sel = 1; K = 1; FS = F_ADD; SL = 1; DA = 13; RW = 1;
    expect_v(OB_REG, 13, 64'h8000_0000_0000_0000, "add_ovf_f");
    expect_v(OB_SF, 0, 64'b1010, "add_ovf_sf"); tick();
    clr(); SA = 6; K_Sel = 1; K = 0; FS = F_AND; SL = 1;
    expect_v(OB_SF, 0, 64'b0001, "and_zero_sf"); tick();
    clr(); K_Sel = 1; K = 0; FS = F_NOTB; SL = 1; DA = 14; RW = 1;
    expect_v(OB_REG, 14, 64'hFFFF_FFFF_FFFF_FFFF, "not_b");
    expect_v(OB_SF, 0, 64'b0010, "not_b_sf"); tick();

    // Branches
    clr(); PS = PS_INC; tick();
    clr(); PS = PS_INC;
    expect_v(OB_PC, 0, 64'h804, "pc_inc_804"); tick();
    clr(); PS = PS_REL; K = 64'hFFFF_FFFF_FFFF_FFFE;
    expect_v(OB_PC, 0, 64'h802, "branch_rel"); tick();
    clr(); DS = 3'b010; K = 64'h900; DA = 10; RW = 1; tick();
    clr(); PS = PS_ABS; PC_Sel = 0; SA = 10;
    expect_v(OB_PC, 0, 64'h900, "branch_reg"); tick();
    clr(); DS = 3'b001; DA = 11; RW = 1;
    expect_v(OB_REG, 11, 64'h901, "ds_pc_plus1"); tick();
    clr(); AS = 1; FS = F_PASSA; DA = 12; RW = 1;
    expect_v(OB_REG, 12, 64'h900, "as_pc_passa"); tick();
    clr(); PS = PS_ABS; PC_Sel = 1; K = 64'hFFFF_FFFF_FFFF_FFFF;
    expect_v(OB_PC, 0, 64'hFFFF_FFFF_FFFF_FFFF, "branch_abs_k"); tick();
    clr(); PS = PS_INC;
    expect_v(OB_PC, 0, 64'h0, "pc_wrap"); tick();

    // MW during fetch writes RAM[PC]; refetch shows it in IR
    clr(); IL = 1; MW = 1; SB = 4; PS = PS_INC;
    expect_v(OB_MEM, 0, 64'd5, "mw_il_mem0");
    expect_v(OB_PC, 0, 64'h1, "mw_il_pc"); tick();
    clr(); PS = PS_ABS; PC_Sel = 1; K = 0; tick();
    clr(); IL = 1; PS = PS_INC; SL = 1; SA = 6; FS = F_PASSA;
    expect_v(OB_IR, 0, 64'd5, "refetch_ir"); tick();

    // Mid-sequence reset
    clr(); rst = 1; RW = 1; DA = 2; DS = 3'b010; K = 99; PS = PS_INC; SL = 1; IL = 1;
    expect_v(OB_PC, 0, 64'h800, "midreset_pc");
    expect_v(OB_IR, 0, 64'h0, "midreset_ir");
    expect_v(OB_SF, 0, 64'h0, "midreset_sf");
    expect_v(OB_REG, 2, 64'h0, "midreset_x2"); tick();

    clr();
    for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
